icache_fetcher: RTL

// - Instruction fetch stage of one compute core; sits directly upstream of the core scheduler.
// - Serves current_pc from a small direct-mapped instruction cache, or fetches from program memory on a miss.
// - Drives fetcher_state; the scheduler leaves FETCH only when it reads FETCHED.
// - Holds the fetched instruction stable for the decoder until the next fetch.

---
 rtl/states_pkg.sv | 27 ++
 rtl/icache_tag_store.sv | 51 +++++
 rtl/icache_fetcher.sv | 103 ++++++++++
 3 files changed

// File: rtl/states_pkg.sv
// rtl/states_pkg.sv - scheduler and fetcher state encodings shared by the fetch stage
package states_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE = 3'b000,
    FETCHING     = 3'b001,
    FETCHED      = 3'b010
  } fetcher_state_t;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// rtl/icache_tag_store.sv - direct-mapped valid/tag/data arrays, combinational lookup, sync write and flush
module icache_tag_store #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_LINES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] lookup_data,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 flush
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_BITS - IDX_W;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [DATA_BITS-1:0] lines [NUM_LINES];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] write_idx;

  assign lookup_idx  = lookup_addr[IDX_W-1:0];
  assign write_idx   = write_addr[IDX_W-1:0];
  assign hit         = valid[lookup_idx] && (tags[lookup_idx] == lookup_addr[ADDR_BITS-1:IDX_W]);
  assign lookup_data = lines[lookup_idx];

  // Flush takes priority so a fill racing a flush never survives as valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (write_en) begin
      valid[write_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[write_idx]  <= write_addr[ADDR_BITS-1:IDX_W];
      lines[write_idx] <= write_data;
    end
  end

endmodule

// File: rtl/icache_fetcher.sv
// rtl/icache_fetcher.sv - instruction fetch stage with direct-mapped icache; FETCH_PERF_EN adds hit/miss counters
module icache_fetcher
  import states_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int NUM_LINES             = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
`endif
);

  fetcher_state_t state;
  logic           flush_seen;
  logic           hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data;
  logic           fill;
  logic           fill_write;

  assign fetcher_state = state;
  assign fill          = (state == FETCHING) && mem_read_ready;
  // A flush seen at any point during this miss keeps the returning line invalid.
  assign fill_write    = fill && !flush && !flush_seen;

  icache_tag_store #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .NUM_LINES (NUM_LINES)
  ) u_tag_store (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (hit),
    .lookup_data (line_data),
    .write_en    (fill_write),
    .write_addr  (mem_read_address),
    .write_data  (mem_read_data),
    .flush       (flush)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      flush_seen       <= 1'b0;
`ifdef FETCH_PERF_EN
      hit_count        <= '0;
      miss_count       <= '0;
`endif
    end else begin
      case (state)
        FETCHER_IDLE: begin
          if (core_state == FETCH) begin
            if (hit) begin
              instruction <= line_data;
              state       <= FETCHED;
`ifdef FETCH_PERF_EN
              hit_count   <= sat_inc(hit_count);
`endif
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              state            <= FETCHING;
`ifdef FETCH_PERF_EN
              miss_count       <= sat_inc(miss_count);
`endif
            end
          end
        end
        FETCHING: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            flush_seen     <= 1'b0;
            state          <= FETCHED;
          end
        end
        FETCHED: begin
          if (core_state == DECODE) state <= FETCHER_IDLE;
        end
        default: state <= FETCHER_IDLE;
      endcase
    end
  end

endmodule
